writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL accept parameter DATA_W, default 32, meaning GPR/HI/LO word width.
REQ-002 SHALL accept parameter ADDR_W, default 5, meaning GPR index width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port WriteRegEnWIn  input  1  GPR write enable from W stage.
REQ-006 SHALL have port WriteRegWIn  input  ADDR_W  GPR write index.
REQ-007 SHALL have port ResultWIn  input  DATA_W  GPR write data.
REQ-008 SHALL have ports HIWriteEnWIn, LOWriteEnWIn  input  1 each  HI/LO write enables.
REQ-009 SHALL have ports ALUHIWIn, ALULOWIn  input  DATA_W each  HI/LO write data.
REQ-010 SHALL have ports RsAddrD, RtAddrD  input  ADDR_W each  decode-stage read indices.
REQ-011 SHALL have ports RsDataD, RtDataD  output  DATA_W each  read data, combinational from address.
REQ-012 SHALL have ports HIDataE, LODataE  output  DATA_W each  current HI/LO values.
REQ-013 SHALL have ports DebugWenW (output 4), DebugWnumW (output ADDR_W), DebugWdataW (output DATA_W)  registered commit trace.

Function
REQ-014 SHALL write ResultWIn to GPR[WriteRegWIn] on rising edge when WriteRegEnWIn=1 and WriteRegWIn!=0.
REQ-015 SHALL ignore writes to index 0; reads of index 0 SHALL return 0 in every cycle.
REQ-016 SHALL write HI and LO independently on the same edge; both enables high updates both.
REQ-017 Read ports SHALL have zero-cycle latency (combinational from RsAddrD/RtAddrD and stored state).
REQ-018 Both read ports reading the same index SHALL return identical data.
REQ-019 DebugWenW SHALL equal 4'b1111 one cycle after a GPR write accepted per REQ-014, else 4'b0000; DebugWnumW/DebugWdataW SHALL hold the committed index/data for that cycle.
REQ-020 A write with WriteRegEnWIn=1 to index 0 SHALL produce DebugWenW=4'b0000.
REQ-021 Write-enable inputs SHALL be treated as already qualified by the W-stage register; no stall/flush input exists.

Reset
REQ-022 reset=0 SHALL asynchronously clear all 31 GPRs, HI, LO to 0 and DebugWenW/DebugWnumW/DebugWdataW to 0.
REQ-023 Any write presented on the edge coinciding with or during reset=0 SHALL be discarded.
REQ-024 First write SHALL take effect on the first rising edge with reset=1.

Configuration
REQ-025 Macro WB_REGFILE_BYPASS_EN, when defined, SHALL make RsDataD/RtDataD return ResultWIn when WriteRegEnWIn=1, WriteRegWIn==read index, index!=0; and HIDataE/LODataE return ALUHIWIn/ALULOWIn when the respective enable is 1.
REQ-026 Without WB_REGFILE_BYPASS_EN, all reads SHALL return stored (pre-edge) values; the hazard unit SHALL stall/forward externally.

Structure
REQ-027 Shared package mips_pkg SHALL hold word_t (DATA_W logic), reg_addr_t (ADDR_W logic), and constant REG_ZERO=0.
REQ-028 HI/LO storage plus its bypass SHALL be a sub-module hilo_reg; the GPR array SHALL be inline.

Verification
REQ-029 Reset: hold reset=0 with writes active, release; read all 32 indices -> all 0, HIDataE=LODataE=0, DebugWenW=0.
REQ-030 Write/read: write 0xDEADBEEF to r5, next cycle RsAddrD=RtAddrD=5 -> both 0xDEADBEEF; DebugWenW=4'hF, DebugWnumW=5, DebugWdataW=0xDEADBEEF.
REQ-031 r0: write 0x12345678 to r0 with enable -> RsDataD(0)=0, DebugWenW=0.
REQ-032 Same-cycle hazard: r7=0x1, write 0x2 to r7 while RsAddrD=7 -> 0x2 with WB_REGFILE_BYPASS_EN, 0x1 without; 0x2 next cycle either way.
REQ-033 HI/LO: HIWriteEnWIn=LOWriteEnWIn=1, data 0xAAAA0000/0x0000BBBB -> next cycle HIDataE=0xAAAA0000, LODataE=0x0000BBBB; then HI-only write 0x1 leaves LO unchanged.
REQ-034 Reset mid-operation: r3=0x55, assert reset=0 asynchronously between edges -> RsDataD(3)=0 immediately, before next clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants for the writeback register file slice.
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t  REG_ZERO    = '0;
    localparam logic [3:0] DBG_WEN_ALL = 4'b1111;
    localparam logic [3:0] DBG_WEN_OFF = 4'b0000;

endpackage

// File: rtl/writeback_regfile_if.sv
// W-stage write, D-stage read, HI/LO and commit-trace signals of the register file.
interface writeback_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              WriteRegEnWIn;
    logic [ADDR_W-1:0] WriteRegWIn;
    logic [DATA_W-1:0] ResultWIn;
    logic              HIWriteEnWIn;
    logic              LOWriteEnWIn;
    logic [DATA_W-1:0] ALUHIWIn;
    logic [DATA_W-1:0] ALULOWIn;
    logic [ADDR_W-1:0] RsAddrD;
    logic [ADDR_W-1:0] RtAddrD;
    logic [DATA_W-1:0] RsDataD;
    logic [DATA_W-1:0] RtDataD;
    logic [DATA_W-1:0] HIDataE;
    logic [DATA_W-1:0] LODataE;
    logic [3:0]        DebugWenW;
    logic [ADDR_W-1:0] DebugWnumW;
    logic [DATA_W-1:0] DebugWdataW;

    modport master (
        output WriteRegEnWIn, WriteRegWIn, ResultWIn,
        output HIWriteEnWIn, LOWriteEnWIn, ALUHIWIn, ALULOWIn,
        output RsAddrD, RtAddrD,
        input  RsDataD, RtDataD, HIDataE, LODataE,
        input  DebugWenW, DebugWnumW, DebugWdataW
    );

    modport slave (
        input  WriteRegEnWIn, WriteRegWIn, ResultWIn,
        input  HIWriteEnWIn, LOWriteEnWIn, ALUHIWIn, ALULOWIn,
        input  RsAddrD, RtAddrD,
        output RsDataD, RtDataD, HIDataE, LODataE,
        output DebugWenW, DebugWnumW, DebugWdataW
    );
endinterface

// File: rtl/writeback_regfile_hilo_reg.sv
// HI/LO special registers with independent write enables.
// WB_REGFILE_BYPASS_EN: reads forward same-cycle write data.
module hilo_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic [DATA_W-1:0] hi_out_c,
    output logic [DATA_W-1:0] lo_out_c
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_wdata;
            if (lo_we) lo_q <= lo_wdata;
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    assign hi_out_c = hi_we ? hi_wdata : hi_q;
    assign lo_out_c = lo_we ? lo_wdata : lo_q;
`else
    assign hi_out_c = hi_q;
    assign lo_out_c = lo_q;
`endif

endmodule

// File: rtl/writeback_regfile.sv
// MIPS GPR file with W-stage write port, two combinational D-stage read ports,
// HI/LO registers and a registered commit trace. WB_REGFILE_BYPASS_EN adds W->D forwarding.
module writeback_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input logic                clk,
    input logic                reset,
    writeback_regfile_if.slave bus
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] gpr [NREG];
    logic              gpr_we_c;
    logic [DATA_W-1:0] rs_data_c;
    logic [DATA_W-1:0] rt_data_c;
    logic [3:0]        dbg_wen;
    logic [ADDR_W-1:0] dbg_wnum;
    logic [DATA_W-1:0] dbg_wdata;

    // Writes to r0 are dropped so that entry stays at its reset value of zero.
    assign gpr_we_c = bus.WriteRegEnWIn && (bus.WriteRegWIn != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) gpr[i] <= '0;
        end else if (gpr_we_c) begin
            gpr[bus.WriteRegWIn] <= bus.ResultWIn;
        end
    end

    always_comb begin
        rs_data_c = '0;
        rt_data_c = '0;
        if (bus.RsAddrD != ADDR_W'(REG_ZERO)) rs_data_c = gpr[bus.RsAddrD];
        if (bus.RtAddrD != ADDR_W'(REG_ZERO)) rt_data_c = gpr[bus.RtAddrD];
`ifdef WB_REGFILE_BYPASS_EN
        // gpr_we_c already excludes r0, so forwarding never makes r0 non-zero.
        if (gpr_we_c && (bus.WriteRegWIn == bus.RsAddrD)) rs_data_c = bus.ResultWIn;
        if (gpr_we_c && (bus.WriteRegWIn == bus.RtAddrD)) rt_data_c = bus.ResultWIn;
`endif
    end

    assign bus.RsDataD = rs_data_c;
    assign bus.RtDataD = rt_data_c;

    // Commit trace: one cycle after an accepted GPR write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_wen   <= DBG_WEN_OFF;
            dbg_wnum  <= '0;
            dbg_wdata <= '0;
        end else begin
            dbg_wen   <= gpr_we_c ? DBG_WEN_ALL : DBG_WEN_OFF;
            dbg_wnum  <= bus.WriteRegWIn;
            dbg_wdata <= bus.ResultWIn;
        end
    end

    assign bus.DebugWenW   = dbg_wen;
    assign bus.DebugWnumW  = dbg_wnum;
    assign bus.DebugWdataW = dbg_wdata;

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk      (clk),
        .reset    (reset),
        .hi_we    (bus.HIWriteEnWIn),
        .lo_we    (bus.LOWriteEnWIn),
        .hi_wdata (bus.ALUHIWIn),
        .lo_wdata (bus.ALULOWIn),
        .hi_out_c (bus.HIDataE),
        .lo_out_c (bus.LODataE)
    );

endmodule
